// File: rtl/ysyx_22040125_pkg.sv
// Shared widths, FSM encoding and M-extension divide op encodings
// for the iterative divider.
package ysyx_22040125_pkg;

    localparam int XLEN  = 64;
    localparam int CNT_W = 7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

    // Encoding is {word, rem, unsigned}
    typedef enum logic [2:0] {
        OP_DIV   = 3'b000,
        OP_DIVU  = 3'b001,
        OP_REM   = 3'b010,
        OP_REMU  = 3'b011,
        OP_DIVW  = 3'b100,
        OP_DIVUW = 3'b101,
        OP_REMW  = 3'b110,
        OP_REMUW = 3'b111
    } div_op_e;

    function automatic logic is_word(input div_op_e op);
        return op[2];
    endfunction

    function automatic logic is_rem(input div_op_e op);
        return op[1];
    endfunction

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/ysyx_22040125_div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit,
// trial-subtract the divisor and emit one quotient bit.
module ysyx_22040125_div_step
    import ysyx_22040125_pkg::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dsr_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Partial remainder is below the divisor, so one extra bit is enough.
    assign shifted = {rem_i, quo_i[XLEN-1]};
    assign diff    = shifted - {1'b0, dsr_i};

    assign rem_o = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_o = {quo_i[XLEN-2:0], ~diff[XLEN]};

endmodule

// File: rtl/ysyx_22040125_divider.sv
// RV64M iterative divider: DIV/DIVU/REM/REMU and *W variants,
// one quotient bit per cycle with valid/ready handshakes.
module ysyx_22040125_divider
    import ysyx_22040125_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    input  logic            op_signed,
    input  logic            op_word,
    input  logic            op_rem,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    div_state_e       state_q;
    div_op_e          op_q;
    logic             special_q;
    logic             qneg_q;
    logic             rneg_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] lim_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  dsr_q;
    logic [XLEN-1:0]  res_q;

    logic [XLEN-1:0]  a_ext;
    logic [XLEN-1:0]  b_ext;
    logic [XLEN-1:0]  a_abs;
    logic [XLEN-1:0]  b_abs;
    logic [XLEN-1:0]  min_v;
    logic [XLEN-1:0]  spec_v;
    logic             a_neg;
    logic             b_neg;
    logic             div_zero;
    logic             ovf;
    logic [XLEN-1:0]  step_rem;
    logic [XLEN-1:0]  step_quo;
    logic [XLEN-1:0]  fin_raw;
    logic [XLEN-1:0]  fin;

    assign a_ext = !op_word ? dividend
                 : op_signed ? sext32(dividend[31:0])
                 : {32'b0, dividend[31:0]};
    assign b_ext = !op_word ? divisor
                 : op_signed ? sext32(divisor[31:0])
                 : {32'b0, divisor[31:0]};

    assign a_neg = op_signed & a_ext[XLEN-1];
    assign b_neg = op_signed & b_ext[XLEN-1];
    assign a_abs = a_neg ? -a_ext : a_ext;
    assign b_abs = b_neg ? -b_ext : b_ext;

    assign min_v    = op_word ? 64'hFFFF_FFFF_8000_0000
                              : 64'h8000_0000_0000_0000;
    assign div_zero = (b_ext == '0);
    assign ovf      = op_signed && (a_ext == min_v) && (b_ext == '1);

    // Special-case answers bypass the iteration entirely
    assign spec_v = div_zero ? (op_rem ? a_ext : '1)
                             : (op_rem ? '0 : a_ext);

    ysyx_22040125_div_step u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dsr_i (dsr_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    assign fin_raw = special_q    ? quo_q
                   : is_rem(op_q) ? (rneg_q ? -rem_q : rem_q)
                   : (qneg_q ? -quo_q : quo_q);
    assign fin = is_word(op_q) ? sext32(fin_raw[31:0]) : fin_raw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= OP_DIV;
            special_q <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            cnt_q     <= '0;
            lim_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dsr_q     <= '0;
            res_q     <= '0;
        end else if (flush) begin
            state_q <= S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        state_q   <= S_CALC;
                        op_q      <= div_op_e'({op_word, op_rem, !op_signed});
                        special_q <= div_zero | ovf;
                        qneg_q    <= a_neg ^ b_neg;
                        rneg_q    <= a_neg;
                        cnt_q     <= '0;
                        rem_q     <= '0;
                        dsr_q     <= b_abs;
                        if (div_zero | ovf) begin
                            lim_q <= '0;
                            quo_q <= spec_v;
                        end else if (op_word) begin
                            lim_q <= 7'd32;
                            quo_q <= {a_abs[31:0], 32'b0};
                        end else begin
                            lim_q <= 7'd64;
                            quo_q <= a_abs;
                        end
                    end
                end
                S_CALC: begin
                    if (cnt_q == lim_q) begin
                        res_q   <= fin;
                        state_q <= S_DONE;
                    end else begin
                        rem_q <= step_rem;
                        quo_q <= step_quo;
                        cnt_q <= cnt_q + 7'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = res_q;

endmodule
